// File: rtl/register_file.sv
// register_file
//   Integer register file for the single-cycle RISC-V core. Two combinational
//   read ports feed the ALU operands; one synchronous write port is driven
//   from writeback. x0 is hardwired to zero.
//
// Ports
//   clock      in   1       system clock, writes land on the rising edge
//   reset_n    in   1       asynchronous active-low reset, clears all registers
//   Read1      in   ADDR_W  read port 1 address
//   Read2      in   ADDR_W  read port 2 address
//   WriteReg   in   ADDR_W  write port address
//   WriteData  in   DATA_W  write data
//   RegWrite   in   1       write enable, active high
//   Data1      out  DATA_W  contents of reg[Read1] (0 for x0 / unimplemented)
//   Data2      out  DATA_W  contents of reg[Read2] (0 for x0 / unimplemented)
module register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2
);

  // x0 has no storage; only x1..x(NUM_REGS-1) are flops.
  logic [DATA_W-1:0] regs_q [NUM_REGS-1:1];
  logic [NUM_REGS-1:1] we_d;

  // One-hot write enable. Address 0 and addresses >= NUM_REGS match no
  // entry, so those writes fall away without any explicit range check.
  always_comb begin
    we_d = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (RegWrite && (WriteReg == ADDR_W'(i))) we_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (we_d[i]) regs_q[i] <= WriteData;
      end
    end
  end

  // Compare-and-select read mux rather than direct indexing: an address of
  // 0, out of range, or X simply selects nothing and reads as 0. Storage
  // contents are never involved in the read path's control, so a bad read
  // address cannot disturb state. Reads during reset see the cleared flops.
  always_comb begin
    Data1 = '0;
    Data2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (Read1 == ADDR_W'(i)) Data1 = regs_q[i];
      if (Read2 == ADDR_W'(i)) Data2 = regs_q[i];
    end
  end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 32;

  logic              clock;
  logic              reset_n;
  logic [ADDR_W-1:0] Read1, Read2, WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [DATA_W-1:0] Data1, Data2;

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clock(clock), .reset_n(reset_n),
    .Read1(Read1), .Read2(Read2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .Data1(Data1), .Data2(Data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: architectural register array; x0 and unimplemented read 0.
  logic [DATA_W-1:0] model [NUM_REGS];

  function automatic logic [DATA_W-1:0] ref_rd(input int a);
    if (a == 0 || a >= NUM_REGS) return '0;
    return model[a];
  endfunction

  task automatic model_write(input int a, input logic [DATA_W-1:0] d, input logic we);
    if (we && a != 0 && a < NUM_REGS) model[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  typedef struct {
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    int                a1;
    int                a2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic smp = 1'b0;

  // Monitor: each sample strobe means the DUT is presenting a read result.
  always @(posedge smp) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sample_without_expectation t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (Data1 !== e.d1) begin
        errors++;
        $display("FAIL data1 addr=%0d got=%h exp=%h t=%0t", e.a1, Data1, e.d1, $time);
      end
      checks++;
      if (Data2 !== e.d2) begin
        errors++;
        $display("FAIL data2 addr=%0d got=%h exp=%h t=%0t", e.a2, Data2, e.d2, $time);
      end
    end
  end

  // Takes 2 time units; callers keep it clear of the rising edge.
  task automatic check_reads(input int a1, input int a2);
    exp_t e;
    Read1 = ADDR_W'(a1);
    Read2 = ADDR_W'(a2);
    e.d1 = ref_rd(a1);
    e.d2 = ref_rd(a2);
    e.a1 = a1;
    e.a2 = a2;
    exp_q.push_back(e);
    #1 smp = 1'b1;
    #1 smp = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d, input logic we);
    @(negedge clock);
    WriteReg  = ADDR_W'(a);
    WriteData = d;
    RegWrite  = we;
    @(posedge clock);
    model_write(a, d, we);
    @(negedge clock);
    RegWrite = 1'b0;
  endtask

  initial begin
    int wa, ra1, ra2;
    logic [DATA_W-1:0] wd;
    logic we;

    model_clear();
    reset_n   = 1'b0;
    Read1     = '0;
    Read2     = '0;
    WriteReg  = '0;
    WriteData = '0;
    RegWrite  = 1'b0;

    // Reads during reset.
    #2 check_reads(7, 10);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check_reads(7, 10);

    // Directed writes then readback.
    do_write(3, 32'hABCDEFFF, 1'b1);
    do_write(5, 32'hFBCDE111, 1'b1);
    check_reads(3, 5);

    // x0 stays zero.
    do_write(0, 32'hDEADBEEF, 1'b1);
    check_reads(0, 3);

    // Out-of-range write dropped; every register unchanged.
    do_write(40, 32'h0BADF00D, 1'b1);
    check_reads(40, 63);
    for (int i = 0; i < NUM_REGS; i += 2) begin
      @(negedge clock);
      check_reads(i, i + 1);
    end

    // Disabled write leaves contents intact.
    do_write(3, 32'h12345678, 1'b0);
    check_reads(3, 3);

    // Read-during-write, same address: old value before the edge, new after.
    @(negedge clock);
    WriteReg  = 6'd9;
    WriteData = 32'hCAFE0009;
    RegWrite  = 1'b1;
    check_reads(9, 9);
    @(posedge clock);
    model_write(9, 32'hCAFE0009, 1'b1);
    #1 check_reads(9, 3);
    @(negedge clock);
    RegWrite = 1'b0;

    // Randomized writes interleaved with reads.
    for (int n = 0; n < 300; n++) begin
      wa = $urandom_range(0, 63);
      wd = $urandom();
      we = ($urandom_range(0, 3) != 0);
      do_write(wa, wd, we);
      ra1 = ($urandom_range(0, 1) != 0) ? wa : $urandom_range(0, 63);
      ra2 = $urandom_range(0, 63);
      check_reads(ra1, ra2);
    end

    // Make sure a few registers are non-zero before the reset test.
    do_write(3, 32'h11111111, 1'b1);
    do_write(31, 32'h3131FFFF, 1'b1);

    // Mid-cycle reset: outputs clear without an edge; a write pending at the
    // following edge loses to reset.
    @(negedge clock);
    Read1 = 6'd3;
    Read2 = 6'd31;
    #2;
    reset_n   = 1'b0;
    WriteReg  = 6'd3;
    WriteData = 32'h77777777;
    RegWrite  = 1'b1;
    model_clear();
    check_reads(3, 31);
    @(posedge clock);
    #1 check_reads(3, 31);
    @(negedge clock);
    RegWrite = 1'b0;
    reset_n  = 1'b1;
    for (int i = 0; i < 64; i += 2) begin
      @(negedge clock);
      check_reads(i, i + 1);
    end

    // Drain: the monitor consumes entries on each strobe, so nothing should remain.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
